host_img_unpacker: RTL and testbench
====================================

Name: host_img_unpacker

Overview:
Reader/decoder side of the 32-bit image word stream. It sits between the host-write FWFT FIFO (fed from /dev/xillybus_write_32) and the image-processing pipeline (ScaleSpaceExtrema io_img_in).
- Pops 32-bit words from the FIFO and recognises the frame sync marker 0xFF000000.
- Converts pixel words to a 24-bit ready/valid pixel stream tagged with start-of-frame, end-of-line and end-of-frame.
- Tracks framing errors and completed frames.

Parameters:
IMG_WIDTH, 640, pixels per line
IMG_HEIGHT, 480, lines per frame
CNT_W, 10, width of column/row counters; must hold max(IMG_WIDTH, IMG_HEIGHT)-1

Ports:
clk  in  1  bus clock
reset  in  1  synchronous, active-high reset
fifo_rd_en  out  1  pop strobe to FWFT FIFO
fifo_valid  in  1  FWFT head word valid
fifo_dout  in  32  FWFT head word
pix_ready  in  1  downstream accepts pixel
pix_valid  out  1  pixel register holds data
pix_bits  out  24  {R8,G8,B8}
pix_sof  out  1  pixel is col 0, row 0
pix_eol  out  1  pixel is col IMG_WIDTH-1
pix_eof  out  1  last pixel of frame
sync_err  out  1  sticky framing error flag
frame_count  out  16  completed frames, wraps 0xFFFF->0

Behaviour:
- Interface: one clock (clk). reset is synchronous and active-high.
- Word classification:
  - Sync word: fifo_dout[31:24]==8'hFF. Lower 24 bits are ignored.
  - Pixel word: any other word. fifo_dout[31:24] is ignored.
- Output stage is a single register. The slot is free when !pix_valid or (pix_valid & pix_ready).
- A pixel word is popped (fifo_rd_en=1) only when fifo_valid & slot free & state==STREAM.
- Sync words and discarded words are popped whenever fifo_valid, regardless of slot state.
- Latency: a pixel popped in cycle N gives pix_valid=1 in cycle N+1. Back-to-back throughput is 1 pixel/cycle.
- pix_valid stays asserted and pix_bits/flags stay stable until pix_ready.
- fifo_rd_en is combinational from the current state, fifo_valid, fifo_dout, pix_valid and pix_ready. It is never asserted when fifo_valid=0.
- Counters: col in 0..IMG_WIDTH-1 and row in 0..IMG_HEIGHT-1, both advanced on each popped pixel.
  - Popped pixel with col==IMG_WIDTH-1 and row==IMG_HEIGHT-1 is the last pixel of the frame.
  - Flags are latched with the pixel: sof=(col==0&&row==0), eol=(col==IMG_WIDTH-1), eof=(last pixel).
- FSM, 3 states:
  - HUNT (reset state): pixel words are popped and silently discarded. Sync -> STREAM, col=row=0.
  - STREAM: on a pixel, load the output register and advance counters. On the last pixel -> WAIT_SYNC.
    - Sync with col|row != 0 (mid-frame): set sync_err, col=row=0, stay in STREAM.
    - Sync with col=row=0: no-op, stay in STREAM.
  - WAIT_SYNC: sync -> STREAM, col=row=0. A pixel word is popped, discarded, and sets sync_err.
- frame_count increments in the cycle pix_valid & pix_ready & pix_eof.
- sync_err clears only on reset.
- Reset mid-operation (all in one cycle): pix_valid=0, any pending pixel is dropped, state=HUNT, counters=0, sync_err=0, frame_count=0, fifo_rd_en=0.
- Reset values: pix_valid=0, pix_bits=0, pix_sof=pix_eol=pix_eof=0, sync_err=0, frame_count=0.
- A sync popped while the output register holds an unaccepted pixel does not alter that pixel or its flags.

Optional Feature:
COLOR_REPLICATE_EN
- Defined: pixel words use the quad format 00000000_RRRRR000_GGGGGG00_BBBBB000. pix_bits is {R5,R5[4:2], G6,G6[5:4], B5,B5[4:2]}, where R5=dout[23:19], G6=dout[15:10], B5=dout[7:3]. This gives full-scale 8-bit expansion.
- Undefined: pix_bits = fifo_dout[23:0] unchanged.

Test Plan:
- IMG_WIDTH=4, IMG_HEIGHT=2, pix_ready=1. Push 0xFF000000 then 8 pixels 0x00000001..0x00000008 -> pix_bits sequence 1..8, each one cycle after its pop. sof on pixel 1, eol on pixels 4 and 8, eof on 8. frame_count=1, sync_err=0.
- Push 3 pixel words after reset, then sync and 8 pixels -> first 3 words discarded with no pix_valid. The frame streams normally, sync_err=0.
- Sync, 5 pixels, sync, 8 pixels -> sync_err=1 after the 2nd sync. The second frame's first pixel has sof=1. frame_count=1.
- Complete frame followed by stray pixel 0x00ABCDEF -> word popped, no pix_valid, sync_err=1.
- Full frame with pix_ready toggling 1,0,0,1 repeatedly -> pix_bits/flags held while ready=0. fifo_rd_en only when the slot is free. No pixel lost or duplicated.
- COLOR_REPLICATE_EN defined, word 0x00F8FCF8 -> pix_bits=0xFFFFFF. Word 0x00080400 -> pix_bits=0x080400. Assert reset mid-frame -> next cycle pix_valid=0, frame_count=0, state HUNT.

Source files
------------

// File: rtl/host_img_unpacker.sv
// host_img_unpacker: pops 32-bit words from a FWFT FIFO, finds 0xFF000000-class frame
// syncs and turns pixel words into a 24-bit ready/valid pixel stream tagged with
// start-of-frame / end-of-line / end-of-frame. Tracks framing errors and completed frames.
// Optional build macro: COLOR_REPLICATE_EN (expand 5/6/5 quad-format words to 8/8/8).
module host_img_unpacker #(
  parameter int unsigned IMG_WIDTH  = 640,
  parameter int unsigned IMG_HEIGHT = 480,
  parameter int unsigned CNT_W      = 10
) (
  input  logic        clk,
  input  logic        reset,
  output logic        fifo_rd_en,
  input  logic        fifo_valid,
  input  logic [31:0] fifo_dout,
  input  logic        pix_ready,
  output logic        pix_valid,
  output logic [23:0] pix_bits,
  output logic        pix_sof,
  output logic        pix_eol,
  output logic        pix_eof,
  output logic        sync_err,
  output logic [15:0] frame_count
);

  localparam logic [CNT_W-1:0] ColMax = CNT_W'(IMG_WIDTH - 1);
  localparam logic [CNT_W-1:0] RowMax = CNT_W'(IMG_HEIGHT - 1);

  typedef enum logic [1:0] {StHunt, StStream, StWaitSync} state_e;

  state_e            state_q, state_d;
  logic [CNT_W-1:0]  col_q, col_d, row_q, row_d;
  logic              pix_valid_q, pix_valid_d;
  logic [23:0]       pix_bits_q, pix_bits_d;
  logic              pix_sof_q, pix_sof_d, pix_eol_q, pix_eol_d, pix_eof_q, pix_eof_d;
  logic              sync_err_q, sync_err_d;
  logic [15:0]       frame_count_q, frame_count_d;

  logic              is_sync, slot_free, pop_pix, pop_sync, pop_stray;
  logic              col_last, row_last;
  logic [23:0]       pix_conv;

  assign is_sync   = (fifo_dout[31:24] == 8'hFF);
  assign slot_free = ~pix_valid_q | pix_ready;
  assign col_last  = (col_q == ColMax);
  assign row_last  = (row_q == RowMax);

`ifdef COLOR_REPLICATE_EN
  // Replicate the top bits into the vacated LSBs so full-scale inputs map to 0xFF.
  assign pix_conv = {fifo_dout[23:19], fifo_dout[23:21],
                     fifo_dout[15:10], fifo_dout[15:14],
                     fifo_dout[7:3],   fifo_dout[7:5]};
  logic unused_fmt_bits;
  assign unused_fmt_bits = ^{fifo_dout[18:16], fifo_dout[9:8], fifo_dout[2:0]};
`else
  assign pix_conv = fifo_dout[23:0];
`endif

  // State register.
  always_ff @(posedge clk) begin
    if (reset) state_q <= StHunt;
    else       state_q <= state_d;
  end

  // Next-state logic.
  always_comb begin
    state_d = state_q;
    case (state_q)
      StHunt:     if (pop_sync) state_d = StStream;
      StStream:   if (pop_pix && col_last && row_last) state_d = StWaitSync;
      StWaitSync: if (pop_sync) state_d = StStream;
      default:    state_d = StHunt;
    endcase
  end

  // FSM outputs: pop strobe and classification of the popped word.
  // Syncs and discarded words drain regardless of the output slot; pixels wait for it.
  always_comb begin
    fifo_rd_en = 1'b0;
    pop_pix    = 1'b0;
    pop_sync   = 1'b0;
    pop_stray  = 1'b0;
    if (fifo_valid && !reset) begin
      if (is_sync) begin
        fifo_rd_en = 1'b1;
        pop_sync   = 1'b1;
      end else begin
        case (state_q)
          StHunt: fifo_rd_en = 1'b1;
          StStream: begin
            if (slot_free) begin
              fifo_rd_en = 1'b1;
              pop_pix    = 1'b1;
            end
          end
          StWaitSync: begin
            fifo_rd_en = 1'b1;
            pop_stray  = 1'b1;
          end
          default: ;
        endcase
      end
    end
  end

  // Datapath next state: counters, output register, error flag, frame counter.
  always_comb begin
    col_d         = col_q;
    row_d         = row_q;
    pix_valid_d   = pix_valid_q;
    pix_bits_d    = pix_bits_q;
    pix_sof_d     = pix_sof_q;
    pix_eol_d     = pix_eol_q;
    pix_eof_d     = pix_eof_q;
    sync_err_d    = sync_err_q;
    frame_count_d = frame_count_q;

    if (pop_sync) begin
      if (state_q == StStream && (col_q != '0 || row_q != '0)) sync_err_d = 1'b1;
      col_d = '0;
      row_d = '0;
    end
    if (pop_stray) sync_err_d = 1'b1;

    if (pop_pix) begin
      pix_valid_d = 1'b1;
      pix_bits_d  = pix_conv;
      pix_sof_d   = (col_q == '0) && (row_q == '0);
      pix_eol_d   = col_last;
      pix_eof_d   = col_last && row_last;
      if (col_last) begin
        col_d = '0;
        row_d = row_last ? '0 : row_q + 1'b1;
      end else begin
        col_d = col_q + 1'b1;
      end
    end else if (pix_ready) begin
      pix_valid_d = 1'b0;
    end

    if (pix_valid_q && pix_ready && pix_eof_q) frame_count_d = frame_count_q + 16'd1;
  end

  // Datapath registers.
  always_ff @(posedge clk) begin
    if (reset) begin
      col_q         <= '0;
      row_q         <= '0;
      pix_valid_q   <= 1'b0;
      pix_bits_q    <= 24'd0;
      pix_sof_q     <= 1'b0;
      pix_eol_q     <= 1'b0;
      pix_eof_q     <= 1'b0;
      sync_err_q    <= 1'b0;
      frame_count_q <= 16'd0;
    end else begin
      col_q         <= col_d;
      row_q         <= row_d;
      pix_valid_q   <= pix_valid_d;
      pix_bits_q    <= pix_bits_d;
      pix_sof_q     <= pix_sof_d;
      pix_eol_q     <= pix_eol_d;
      pix_eof_q     <= pix_eof_d;
      sync_err_q    <= sync_err_d;
      frame_count_q <= frame_count_d;
    end
  end

  assign pix_valid   = pix_valid_q;
  assign pix_bits    = pix_bits_q;
  assign pix_sof     = pix_sof_q;
  assign pix_eol     = pix_eol_q;
  assign pix_eof     = pix_eof_q;
  assign sync_err    = sync_err_q;
  assign frame_count = frame_count_q;

endmodule

// File: tb/tb_host_img_unpacker.sv
// Directed bench for host_img_unpacker with a 4x2 image. A queue stands in for the FWFT FIFO
// and accepted pixels are captured as {sof,eol,eof,bits} for comparison.
module tb_host_img_unpacker;

  localparam int unsigned W = 4;
  localparam int unsigned H = 2;

  logic        clk = 1'b0;
  logic        reset;
  logic        fifo_rd_en;
  logic        fifo_valid;
  logic [31:0] fifo_dout;
  logic        pix_ready;
  logic        pix_valid;
  logic [23:0] pix_bits;
  logic        pix_sof, pix_eol, pix_eof;
  logic        sync_err;
  logic [15:0] frame_count;

  always #5 clk = ~clk;

  host_img_unpacker #(.IMG_WIDTH(W), .IMG_HEIGHT(H), .CNT_W(3)) dut (
    .clk         (clk),
    .reset       (reset),
    .fifo_rd_en  (fifo_rd_en),
    .fifo_valid  (fifo_valid),
    .fifo_dout   (fifo_dout),
    .pix_ready   (pix_ready),
    .pix_valid   (pix_valid),
    .pix_bits    (pix_bits),
    .pix_sof     (pix_sof),
    .pix_eol     (pix_eol),
    .pix_eof     (pix_eof),
    .sync_err    (sync_err),
    .frame_count (frame_count)
  );

  logic [31:0] fifo_q[$];
  logic [26:0] out_q[$];
  int          checks = 0;
  int          errors = 0;
  logic        hold;
  logic [26:0] hold_val;
  logic        popped;
  bit          slot_chk;
  int          valid_seen;
  logic [23:0] exp_a;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // One clock cycle: present FIFO head, sample mid-cycle, then pop on the edge if strobed.
  task automatic step(input logic rdy);
    fifo_valid = (fifo_q.size() > 0);
    fifo_dout  = fifo_valid ? fifo_q[0] : 32'h0;
    pix_ready  = rdy;
    #4;
    popped = fifo_rd_en;
    chk("rd_gate", {31'd0, fifo_rd_en & ~fifo_valid}, 32'd0);
    if (hold) begin
      chk("hold_valid", {31'd0, pix_valid}, 32'd1);
      chk("hold_data", {5'd0, pix_sof, pix_eol, pix_eof, pix_bits}, {5'd0, hold_val});
    end
    if (slot_chk && popped && fifo_dout[31:24] != 8'hFF)
      chk("rd_slot", {31'd0, ~pix_valid | pix_ready}, 32'd1);
    if (pix_valid) valid_seen++;
    if (pix_valid && pix_ready) out_q.push_back({pix_sof, pix_eol, pix_eof, pix_bits});
    hold     = pix_valid & ~pix_ready;
    hold_val = {pix_sof, pix_eol, pix_eof, pix_bits};
    @(posedge clk);
    #1;
    if (popped) void'(fifo_q.pop_front());
  endtask

  task automatic do_reset();
    reset = 1'b1;
    step(1'b1);
    chk("rst_rd_en", {31'd0, popped}, 32'd0);
    reset      = 1'b0;
    hold       = 1'b0;
    valid_seen = 0;
    out_q.delete();
  endtask

  task automatic push_frame(input logic [31:0] first, input int n);
    for (int i = 0; i < n; i++) fifo_q.push_back(first + i);
  endtask

  // Compare 8 captured pixels starting at base against a full 4x2 frame.
  task automatic chk_frame(input int base, input logic [23:0] first);
    for (int i = 0; i < 8; i++) begin
      logic [26:0] e;
      e = {(i == 0), (i % 4 == 3), (i == 7), first + 24'(i)};
      if (base + i < out_q.size()) chk("out_pix", {5'd0, out_q[base + i]}, {5'd0, e});
      else chk("out_missing", out_q.size(), base + i + 1);
    end
  endtask

  initial begin
    reset      = 1'b1;
    fifo_valid = 1'b0;
    fifo_dout  = 32'h0;
    pix_ready  = 1'b1;
    hold       = 1'b0;
    slot_chk   = 1'b0;
    valid_seen = 0;
    @(posedge clk);
    #1;

    // Reset values
    do_reset();
    chk("rst_valid", {31'd0, pix_valid}, 32'd0);
    chk("rst_bits", {8'd0, pix_bits}, 32'd0);
    chk("rst_flags", {29'd0, pix_sof, pix_eol, pix_eof}, 32'd0);
    chk("rst_err", {31'd0, sync_err}, 32'd0);
    chk("rst_fc", {16'd0, frame_count}, 32'd0);

    // T1: sync + one frame, one-cycle latency
    fifo_q.push_back(32'hFF00_0000);
    push_frame(32'd1, 8);
    step(1'b1);
    chk("t1_sync_pop", {31'd0, popped}, 32'd1);
    chk("t1_no_valid", {31'd0, pix_valid}, 32'd0);
    step(1'b1);
    chk("t1_pix_pop", {31'd0, popped}, 32'd1);
    chk("t1_latency", {6'd0, pix_valid, pix_sof, pix_bits}, {6'd0, 1'b1, 1'b1, 24'd1});
    repeat (10) step(1'b1);
    chk("t1_count", out_q.size(), 32'd8);
    chk_frame(0, 24'd1);
    chk("t1_fc", {16'd0, frame_count}, 32'd1);
    chk("t1_err", {31'd0, sync_err}, 32'd0);

    // T2: leading pixels discarded while hunting
    do_reset();
    fifo_q.push_back(32'h11);
    fifo_q.push_back(32'h22);
    fifo_q.push_back(32'h33);
    repeat (3) step(1'b1);
    chk("t2_discard", valid_seen, 32'd0);
    chk("t2_drained", fifo_q.size(), 32'd0);
    fifo_q.push_back(32'hFF12_3456);
    push_frame(32'd1, 8);
    repeat (12) step(1'b1);
    chk("t2_count", out_q.size(), 32'd8);
    chk_frame(0, 24'd1);
    chk("t2_err", {31'd0, sync_err}, 32'd0);
    chk("t2_fc", {16'd0, frame_count}, 32'd1);

    // T3: mid-frame sync restarts the frame and flags an error
    do_reset();
    fifo_q.push_back(32'hFF00_0000);
    push_frame(32'd1, 5);
    fifo_q.push_back(32'hFF00_0000);
    push_frame(32'h11, 8);
    repeat (18) step(1'b1);
    chk("t3_count", out_q.size(), 32'd13);
    for (int i = 0; i < 5; i++) begin
      if (i < out_q.size())
        chk("t3_part", {5'd0, out_q[i]},
            {5'd0, (i == 0), (i == 3), 1'b0, 24'(i + 1)});
    end
    chk_frame(5, 24'h11);
    chk("t3_err", {31'd0, sync_err}, 32'd1);
    chk("t3_fc", {16'd0, frame_count}, 32'd1);

    // T4: stray pixel after a completed frame
    do_reset();
    fifo_q.push_back(32'hFF00_0000);
    push_frame(32'd1, 8);
    fifo_q.push_back(32'h00AB_CDEF);
    repeat (12) step(1'b1);
    chk("t4_count", out_q.size(), 32'd8);
    chk("t4_drained", fifo_q.size(), 32'd0);
    chk("t4_err", {31'd0, sync_err}, 32'd1);
    chk("t4_fc", {16'd0, frame_count}, 32'd1);

    // T5: backpressure pattern 1,0,0,1
    do_reset();
    slot_chk = 1'b1;
    fifo_q.push_back(32'hFF00_0000);
    push_frame(32'd1, 8);
    for (int i = 0; i < 40; i++) step((i % 4 == 0) || (i % 4 == 3));
    slot_chk = 1'b0;
    chk("t5_count", out_q.size(), 32'd8);
    chk_frame(0, 24'd1);
    chk("t5_fc", {16'd0, frame_count}, 32'd1);
    chk("t5_err", {31'd0, sync_err}, 32'd0);

    // T6: pixel format, then reset mid-frame with a pending pixel
`ifdef COLOR_REPLICATE_EN
    exp_a = 24'hFFFFFF;
`else
    exp_a = 24'hF8FCF8;
`endif
    out_q.delete();
    fifo_q.push_back(32'hFF00_0000);
    fifo_q.push_back(32'h00F8_FCF8);
    fifo_q.push_back(32'h0008_0400);
    repeat (3) step(1'b1);
    step(1'b0);
    chk("t6_count", out_q.size(), 32'd1);
    if (out_q.size() > 0) chk("t6_pix_a", {8'd0, out_q[0][23:0]}, {8'd0, exp_a});
    chk("t6_pix_b", {7'd0, pix_valid, pix_bits}, {7'd0, 1'b1, 24'h080400});
    chk("t6_fc_pre", {16'd0, frame_count}, 32'd1);
    fifo_q.push_back(32'h0000_0055);
    reset = 1'b1;
    step(1'b0);
    chk("t6_rst_rd", {31'd0, popped}, 32'd0);
    reset = 1'b0;
    hold  = 1'b0;
    chk("t6_rst_valid", {31'd0, pix_valid}, 32'd0);
    chk("t6_rst_fc", {16'd0, frame_count}, 32'd0);
    chk("t6_rst_err", {31'd0, sync_err}, 32'd0);
    valid_seen = 0;
    repeat (3) step(1'b1);
    chk("t6_hunt_discard", valid_seen, 32'd0);
    chk("t6_hunt_drained", fifo_q.size(), 32'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
